// File: rtl/keypad_scan_tdm.sv
// 4x4 matrix keypad scanner: drives one column low at a time, debounces whole
// scans and emits one-cycle press events plus a four-digit history for display.
module keypad_scan_tdm #(
    parameter int SCAN_DIV = 100000,
    parameter int DEBOUNCE = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  row,
    output logic [3:0]  col,
    output logic [3:0]  key_code,
    output logic        key_valid,
    output logic        key_down,
    output logic [15:0] digits
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [3:0] DEB = 4'(DEBOUNCE);

    // MULTI collapses to NONE at decode time, so a result is either NONE or KEY(code)
    typedef struct packed {
        logic       is_key;
        logic [3:0] code;
    } res_t;

    localparam res_t RES_NONE = '{is_key: 1'b0, code: 4'h0};

    function automatic logic [3:0] key_map(input logic [1:0] c, input logic [1:0] r);
        logic [3:0] code;
        case ({r, c})
            4'h0: code = 4'h1;
            4'h1: code = 4'h2;
            4'h2: code = 4'h3;
            4'h3: code = 4'hA;
            4'h4: code = 4'h4;
            4'h5: code = 4'h5;
            4'h6: code = 4'h6;
            4'h7: code = 4'hB;
            4'h8: code = 4'h7;
            4'h9: code = 4'h8;
            4'hA: code = 4'h9;
            4'hB: code = 4'hC;
            4'hC: code = 4'h0;
            4'hD: code = 4'hF;
            4'hE: code = 4'hE;
            4'hF: code = 4'hD;
            default: code = 4'h0;
        endcase
        return code;
    endfunction

    // closed[c*4+r] is set when switch (column c, row r) was seen closed
    function automatic res_t decode(input logic [15:0] closed);
        logic [4:0] n;
        res_t       hit;
        n   = 5'd0;
        hit = RES_NONE;
        for (int i = 0; i < 16; i++) begin
            if (closed[i]) begin
                n   = n + 5'd1;
                hit = '{is_key: 1'b1, code: key_map(2'(i / 4), 2'(i % 4))};
            end else begin
                n   = n;
            end
        end
        return (n == 5'd1) ? hit : RES_NONE;
    endfunction

    logic [3:0]       row_s1_q, row_s1_d, row_s2_q, row_s2_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [1:0]       idx_q, idx_d;
    logic [3:0]       col_q, col_d;
    logic [15:0]      acc_q, acc_d;
    res_t             res_q, res_d;
    logic             eval_q, eval_d;
    res_t             cand_q, cand_d;
    logic [3:0]       cnt_q, cnt_d;
    res_t             stable_q, stable_d;
    logic [3:0]       key_code_q, key_code_d;
    logic             key_valid_q, key_valid_d;
    logic             key_down_q, key_down_d;
    logic [15:0]      digits_q, digits_d;

    logic [15:0] cur_s;
    res_t        cand_n_s;
    logic [3:0]  cnt_n_s;

    // Next-state: synchronizer, column scan, scan accumulation, debounce and acceptance
    always_comb begin
        row_s1_d    = row;
        row_s2_d    = row_s1_q;
        div_d       = div_q;
        idx_d       = idx_q;
        col_d       = col_q;
        acc_d       = acc_q;
        res_d       = res_q;
        eval_d      = 1'b0;
        cand_d      = cand_q;
        cnt_d       = cnt_q;
        stable_d    = stable_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        key_down_d  = key_down_q;
        digits_d    = digits_q;
        cand_n_s    = cand_q;
        cnt_n_s     = cnt_q;
        cur_s       = {12'h000, ~row_s2_q} << {idx_q, 2'b00};

        if (div_q == DIV_LAST) begin
            div_d = '0;
            idx_d = idx_q + 2'd1;
            col_d = ~(4'b0001 << idx_d);
            if (idx_q == 2'd3) begin
                res_d  = decode(acc_q | cur_s);
                acc_d  = 16'h0000;
                eval_d = 1'b1;
            end else begin
                acc_d  = acc_q | cur_s;
            end
        end else begin
            div_d = div_q + DIV_W'(1);
        end

        // One cycle after the scan result lands, fold it into the debouncer
        if (eval_q) begin
            if (res_q == cand_q) begin
                cand_n_s = cand_q;
                cnt_n_s  = (cnt_q < DEB) ? cnt_q + 4'd1 : cnt_q;
            end else begin
                cand_n_s = res_q;
                cnt_n_s  = 4'd1;
            end
            cand_d = cand_n_s;
            cnt_d  = cnt_n_s;
            if ((cnt_n_s == DEB) && (cand_n_s != stable_q)) begin
                stable_d = cand_n_s;
                if (cand_n_s.is_key) begin
                    key_code_d  = cand_n_s.code;
                    digits_d    = {digits_q[11:0], cand_n_s.code};
                    key_down_d  = 1'b1;
                    key_valid_d = 1'b1;
                end else begin
                    key_down_d  = 1'b0;
                end
            end else begin
                stable_d = stable_q;
            end
        end else begin
            cand_d = cand_q;
        end
    end

    // State register with synchronous reset; idle rows read as all-high
    always_ff @(posedge clk) begin
        if (rst) begin
            row_s1_q    <= 4'hF;
            row_s2_q    <= 4'hF;
            div_q       <= '0;
            idx_q       <= 2'd0;
            col_q       <= 4'b1110;
            acc_q       <= 16'h0000;
            res_q       <= RES_NONE;
            eval_q      <= 1'b0;
            cand_q      <= RES_NONE;
            cnt_q       <= 4'd0;
            stable_q    <= RES_NONE;
            key_code_q  <= 4'h0;
            key_valid_q <= 1'b0;
            key_down_q  <= 1'b0;
            digits_q    <= 16'h0000;
        end else begin
            row_s1_q    <= row_s1_d;
            row_s2_q    <= row_s2_d;
            div_q       <= div_d;
            idx_q       <= idx_d;
            col_q       <= col_d;
            acc_q       <= acc_d;
            res_q       <= res_d;
            eval_q      <= eval_d;
            cand_q      <= cand_d;
            cnt_q       <= cnt_d;
            stable_q    <= stable_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_down_q  <= key_down_d;
            digits_q    <= digits_d;
        end
    end

    assign col       = col_q;
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_down  = key_down_q;
    assign digits    = digits_q;

endmodule

// File: tb/tb_keypad_scan_tdm.sv
// Bench for keypad_scan_tdm: keypad switch model, scan-level reference model,
// and a scoreboard monitor that checks every key_valid pulse.
module tb_keypad_scan_tdm;

    localparam int SD = 4;
    localparam int DB = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_down;
    logic [15:0] digits;
    logic [15:0] sw = 16'h0000;

    always #5 clk = ~clk;

    keypad_scan_tdm #(.SCAN_DIV(SD), .DEBOUNCE(DB)) dut (
        .clk(clk), .rst(rst), .row(row), .col(col),
        .key_code(key_code), .key_valid(key_valid),
        .key_down(key_down), .digits(digits)
    );

    // sw[c*4+r] closed pulls row r low while column c is driven low
    always_comb begin
        row = 4'hF;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                if (sw[c*4+r] && !col[c]) row[r] = 1'b0;
    end

    typedef struct {
        logic [3:0]  code;
        logic [15:0] dig;
        int          cyc;
    } ev_t;

    ev_t         evq[$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          k = 0;
    logic        prev_valid = 1'b0;

    logic [3:0]  tbl [16] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                              4'h7, 4'h8, 4'h9, 4'hC, 4'h0, 4'hF, 4'hE, 4'hD};
    int          hist[$];
    int          stable = -1;
    logic [3:0]  m_code = 4'h0;
    logic [15:0] m_digits = 16'h0000;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int scan_result(input logic [15:0] m);
        if ($countones(m) != 1) return -1;
        for (int i = 0; i < 16; i++)
            if (m[i]) return int'(tbl[(i % 4) * 4 + i / 4]);
        return -1;
    endfunction

    // A scan result is accepted once the last DB results agree and differ from the stable state
    task automatic model_scan(input logic [15:0] m, input int cyc_e);
        int r;
        bit same;
        r = scan_result(m);
        hist.push_back(r);
        same = (hist.size() >= DB);
        for (int j = 0; j < DB && same; j++)
            if (hist[hist.size() - 1 - j] != r) same = 1'b0;
        if (same && r != stable) begin
            stable = r;
            if (r >= 0) begin
                m_code   = 4'(r);
                m_digits = {m_digits[11:0], 4'(r)};
                evq.push_back('{code: m_code, dig: m_digits, cyc: cyc_e + 2});
            end
        end
    endtask

    // Called just after a scan-end edge (or right after reset release); runs one full scan
    task automatic run_scan(input logic [15:0] m);
        #1 sw = m;
        @(posedge clk);
        #1;
        chk("key_down", {31'd0, key_down}, {31'd0, (stable >= 0)});
        chk("key_code", {28'd0, key_code}, {28'd0, m_code});
        chk("digits", {16'd0, digits}, {16'd0, m_digits});
        repeat (15) @(posedge clk);
        model_scan(m, cyc);
    endtask

    task automatic do_reset(input int n);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        hist.delete();
        stable   = -1;
        m_code   = 4'h0;
        m_digits = 16'h0000;
        repeat (n) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Cycles since the last reset edge, used for the expected column drive
    always @(posedge clk) begin
        if (rst) k <= 0;
        else     k <= k + 1;
    end

    // Monitor: column walk every cycle, scoreboard pop on every key_valid pulse
    always @(negedge clk) begin
        logic [3:0] exp_col;
        ev_t e;
        cyc = cyc + 1;
        exp_col = ~(4'b0001 << ((k / SD) % 4));
        chk("col", {28'd0, col}, {28'd0, exp_col});
        if (key_valid) begin
            chk("pulse_single_cycle", {31'd0, prev_valid}, 32'd0);
            if (evq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_pulse actual=key_valid,code=%h required=no pulse at %0t", key_code, $time);
            end else begin
                e = evq.pop_front();
                chk("pulse_code", {28'd0, key_code}, {28'd0, e.code});
                chk("pulse_digits", {16'd0, digits}, {16'd0, e.dig});
                chk("pulse_cycle", cyc, e.cyc);
            end
        end
        prev_valid = key_valid;
    end

    initial begin
        int b1, b2, kind, hold;
        logic [15:0] m;

        do_reset(2);
        repeat (10) run_scan(16'h0000);

        repeat (10) run_scan(16'h0020);
        chk("press_code", {28'd0, key_code}, 32'h5);
        chk("press_digits", {16'd0, digits}, 32'h0005);

        repeat (4) run_scan(16'h0000);
        for (int i = 0; i < 6; i++) run_scan((i % 2 == 0) ? 16'h0001 : 16'h0000);
        repeat (2) run_scan(16'h0000);
        chk("bounce_digits", {16'd0, digits}, 32'h0005);

        foreach (tbl[i]) begin
            if (i < 4) begin
                m = 16'h0001 << (i * 4);
                repeat (3) run_scan(m);
                repeat (3) run_scan(16'h0000);
            end
        end
        chk("seq_digits", {16'd0, digits}, 32'h123A);
        chk("seq_code", {28'd0, key_code}, 32'hA);

        repeat (5) run_scan(16'h0801);
        repeat (3) run_scan(16'h0001);
        repeat (2) run_scan(16'h0000);
        chk("multi_code", {28'd0, key_code}, 32'h1);

        repeat (3) run_scan(16'h0040);
        do_reset(1);
        repeat (4) run_scan(16'h0040);
        chk("rst_press_digits", {16'd0, digits}, 32'h0008);
        repeat (2) run_scan(16'h0000);

        for (int n = 0; n < 60; n++) begin
            kind = $urandom_range(0, 3);
            hold = $urandom_range(1, 4);
            b1   = $urandom_range(0, 15);
            b2   = (b1 + 1 + $urandom_range(0, 14)) % 16;
            case (kind)
                0:       m = 16'h0000;
                3:       m = (16'h0001 << b1) | (16'h0001 << b2);
                default: m = 16'h0001 << b1;
            endcase
            repeat (hold) run_scan(m);
        end
        repeat (3) run_scan(16'h0000);

        repeat (2) @(posedge clk);
        #1;
        chk("queue_empty", evq.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/keypad_scan_tdm.md
Name: keypad_scan_tdm

Overview:
- Time-multiplexed 4x4 matrix keypad scanner (PmodKYPD-style).
- Input-side counterpart to the multiplexed seven-segment display driver.
- Drives one column low at a time, samples the row lines, debounces whole scans, and emits one-cycle key-press events.
- Keeps the last four key codes in a 16-bit shift register that feeds the display `data` input directly.

Parameters:
- SCAN_DIV, 100000, clock cycles per column period (1 ms at 100 MHz); legal minimum 4.
- DEBOUNCE, 4, consecutive identical full-scan results required before a state change is accepted; legal range 1..15.

Ports:
- clk  input  1  system clock, single clock domain.
- rst  input  1  synchronous, active-high reset.
- row  input  4  keypad row lines, active-low; asynchronous pins.
- col  output 4  keypad column drives, active-low, exactly one bit low.
- key_code  output 4  hex code of the last accepted key.
- key_valid  output 1  one-cycle pulse on an accepted press.
- key_down  output 1  level, high while the accepted state is a single key.
- digits  output 16  last four accepted codes, newest in [3:0].

Behaviour:
- Clock and reset: one clock is used. Reset is synchronous and active-high. All state is cleared on the rst edge.
- Reset values: col=4'b1110, key_code=0, key_valid=0, key_down=0, digits=16'h0000. Column index=0, divider=0, candidate=NONE, match count=0, stable state=NONE.
- Row synchronizer: `row` passes through a 2-flop synchronizer. All sampling uses the synchronized value. The synchronizer is also reset.
- Scanning:
  - The divider counts 0..SCAN_DIV-1 and wraps.
  - The column index advances 0→1→2→3→0 on divider wrap.
  - col = ~(4'b0001 << index).
- Sampling: at the edge where divider==SCAN_DIV-1, the synchronized row for the current column is captured into a per-scan accumulator. The column index then advances on that same edge.
- Key map, (column, row) → code:
  - row0: c0=1, c1=2, c2=3, c3=A
  - row1: c0=4, c1=5, c2=6, c3=B
  - row2: c0=7, c1=8, c2=9, c3=C
  - row3: c0=0, c1=F, c2=E, c3=D
- Scan result: taken at the column-3 sample edge (edge E).
  - NONE if no row bit is low in any column.
  - KEY(k) if exactly one switch is closed.
  - MULTI if two or more are closed. MULTI is treated as NONE everywhere downstream.
  - The scan result is registered at E, and the accumulator clears at E.
- Debounce, evaluated at edge E+1:
  - If result==candidate: match count increments, saturating at DEBOUNCE.
  - Otherwise: candidate<=result and match count<=1.
- Acceptance: when the updated count equals DEBOUNCE and candidate≠stable, then stable<=candidate, and the outputs update at E+1:
  - NONE→KEY(k): key_code<=k, digits<={digits[11:0],k}, key_down<=1, key_valid=1.
  - KEY(k)→KEY(j), j≠k, with no intervening NONE: treated as a new press. key_code<=j, shift j into digits, key_valid=1.
  - KEY→NONE: key_down<=0. key_code and digits are held. No pulse.
- key_valid is high only in the cycle after E+1. It is never high in two consecutive cycles.
- Holding a key produces no repeats.
- Reset while a key is held: the key is re-detected as a new press after DEBOUNCE full scans from the reset point.
- An asynchronous glitch shorter than one column period affects at most one scan result and cannot be accepted when DEBOUNCE≥2.

Test Plan (SCAN_DIV=4, DEBOUNCE=2, scan period=16 cycles; keypad model pulls row[r] low while col[c] is low and switch (c,r) is closed):
- Reset/idle: assert rst for 2 cycles, then release → col=1110 immediately after reset, then 1101, 1011, 0111 in 4-cycle steps; all other outputs 0; no key_valid in 10 scans.
- Single press: close (c1,r1) and hold for 10 scans → exactly one key_valid pulse at the end of the 2nd full scan; key_code=5, digits=16'h0005, key_down=1; no further pulses.
- Release and bounce: release the key → key_down=0 after 2 scans, no pulse, key_code still 5. Then toggle (c0,r0) open/closed on alternate scans for 6 scans → no pulse, digits unchanged.
- Sequence: press and release 1, 2, 3, A in turn (each held 3 scans, released 3 scans) → 4 pulses; digits=16'h123A; key_code=A.
- Multi-key: close (c0,r0) and (c2,r3) together for 5 scans → no pulse, key_down=0. Then open (c2,r3) → after 2 scans one pulse, key_code=1.
- Reset mid-press: hold 8 (c1,r2), accepted; assert rst 1 cycle → all outputs 0. Keep holding → one new pulse with key_code=8 at the end of the 2nd scan after reset; digits=16'h0008.
